vend_input: RTL
===============

# vend_input

Input front-end for the vending machine. It debounces the product-select, coin and cancel pushbuttons, all sampled on the 1 ms clock. It tracks the currently selected product code and the accumulated coin credit. It issues one-cycle event pulses to the main controller FSM. Its `CurrProd` and `money` outputs are the same 4-bit buses the seven-segment display driver consumes, so product codes are 4'hA–4'hE and credit is unsigned 0–15.

## Interface
Parameters:
- `DEB_MS`, 20, consecutive stable samples required to accept a level change (≥2)
- `COIN0_VAL`, 1, credit added by coin button 0
- `COIN1_VAL`, 2, credit added by coin button 1
- `COIN2_VAL`, 5, credit added by coin button 2

Ports:
- `clk_1ms` input 1: 1 ms system clock; one clock; all logic on rising edge
- `rst` input 1: reset, synchronous, active-high
- `btn_prod` input 5: raw product buttons, bit0=A … bit4=E, active-high, asynchronous
- `btn_coin` input 3: raw coin buttons, active-high, asynchronous
- `btn_cancel` input 1: raw cancel button, active-high, asynchronous
- `accept_sel` input 1: controller is in product-select state
- `accept_coin` input 1: controller is in amount-select state
- `money_clr` input 1: one-cycle pulse from controller; zero credit (vend/change/refund done)
- `CurrProd` output 4: selected product code, 4'h0 = none
- `money` output 4: accumulated credit
- `prod_pulse` output 1: one-cycle pulse, new product latched
- `coin_pulse` output 1: one-cycle pulse, coin credited
- `coin_reject` output 1: one-cycle pulse, coin refused
- `cancel_pulse` output 1: one-cycle pulse, cancel pressed

## Operation
- Per button (9 total): a 2-flop synchronizer produces `s`. The debounced level is `db`, with a counter sized for `DEB_MS`.
  - If `s == db`, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches `DEB_MS-1` with `s != db`, `db <= s` and the counter clears.
  - Glitches shorter than `DEB_MS` samples are ignored. Release is debounced identically.
- Rising edge of `db` (previous 0, now 1) = press event. Release generates no event.
- Product press, only when `accept_sel` = 1:
  - `CurrProd <= 4'hA + index` and `prod_pulse` asserts.
  - Simultaneous presses: lowest index wins; the others are discarded.
  - Presses while `accept_sel` = 0 are discarded silently.
- Coin press:
  - If `accept_coin` = 0, `coin_reject` pulses and credit is unchanged.
  - Else, if `money + val > 15`, `coin_reject` pulses and credit is unchanged. No wrap-around; the 5-bit sum is compared.
  - Else `money <= money + val` and `coin_pulse` asserts.
  - Simultaneous coin events: lowest index is processed, and `coin_reject` pulses once for the rest. If the lowest is itself rejected, a single `coin_reject` pulse covers all.
- Cancel press: `cancel_pulse` asserts regardless of `accept_*`. It does not clear `money` or `CurrProd`; the controller decides.
- `money_clr`: `money <= 0` and `CurrProd <= 4'h0`. If a coin event lands in the same cycle, `money_clr` is applied first and the coin is then evaluated against 0. Result `money = val` with `coin_pulse`; credit is never lost.
- Product press in the same cycle as `money_clr` with `accept_sel` = 1: the new product is latched (press wins over clear for `CurrProd`).

## Timing
- Reset values:
  - `CurrProd` = 4'h0, `money` = 4'h0, all pulses = 0.
  - All synchronizers, `db` levels and counters = 0.
- Reset mid-debounce: counter discarded. A button held through reset is re-debounced from zero and produces a press event after release of `rst`, at full latency.
- Latency: raw input high before edge k and held → `db` high after edge k+1+`DEB_MS` → pulse and `CurrProd`/`money` update visible after edge k+2+`DEB_MS`, for exactly one cycle.
- `accept_*` is sampled in the same cycle the press event is evaluated, i.e. the cycle before the outputs update.
- `money_clr` takes effect on the next edge; single-cycle latency.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- `DEB_MS`=4, `accept_sel`=1: hold `btn_prod[2]` for 10 cycles → one `prod_pulse` 6 edges after first sample, `CurrProd`=4'hC; releasing gives no pulse.
- 3-cycle glitch on `btn_coin[0]` with `accept_coin`=1 → no `coin_pulse`, `money` stays 0.
- Coins 5, 5, 2, 2 pressed sequentially → `money` 5, 10, 12, 14. Then coin 2 → `coin_reject`, `money` stays 14. Then coin 1 → `money`=15.
- `btn_prod[1]` and `btn_prod[3]` pressed in the same cycle → `CurrProd`=4'hB. With `accept_sel`=0, pressing E leaves `CurrProd` unchanged and gives no pulse.
- `money`=9; `money_clr` in the same cycle as the coin-2 event → `money`=5, `coin_pulse`=1, `CurrProd`=4'h0.
- Assert `rst` while `btn_cancel` is held mid-debounce → all outputs 0. `cancel_pulse` appears 6 edges after `rst` deasserts.

Source files
------------

// File: rtl/vend_input.sv
// vend_input: debounced button front-end tracking product selection and coin credit
module vend_input #(
    parameter int DEB_MS    = 20,
    parameter int COIN0_VAL = 1,
    parameter int COIN1_VAL = 2,
    parameter int COIN2_VAL = 5
) (
    input  logic       clk_1ms,
    input  logic       rst,
    input  logic [4:0] btn_prod,
    input  logic [2:0] btn_coin,
    input  logic       btn_cancel,
    input  logic       accept_sel,
    input  logic       accept_coin,
    input  logic       money_clr,
    output logic [3:0] CurrProd,
    output logic [3:0] money,
    output logic       prod_pulse,
    output logic       coin_pulse,
    output logic       coin_reject,
    output logic       cancel_pulse
);
    localparam int CW = $clog2(DEB_MS);

    logic [8:0]    w_raw, w_press, r_s1, r_s2, r_db, r_db_d;
    logic [CW-1:0] r_cnt [9];
    logic [4:0]    w_pp;
    logic [2:0]    w_cp, w_pidx;
    logic [1:0]    w_cidx;
    logic [4:0]    w_val, w_base, w_sum;
    logic          w_cok, w_multi;
    logic [3:0]    r_prod, r_money;
    logic          r_prod_pulse, r_coin_pulse, r_coin_reject, r_cancel_pulse;

    assign w_raw   = {btn_cancel, btn_coin, btn_prod};
    assign w_press = r_db & ~r_db_d;
    assign w_pp    = w_press[4:0];
    assign w_cp    = w_press[7:5];

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            r_db_d <= '0;
            for (int i = 0; i < 9; i++) r_cnt[i] <= '0;
        end else begin
            r_s1   <= w_raw;
            r_s2   <= r_s1;
            r_db_d <= r_db;
            for (int i = 0; i < 9; i++) begin
                if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
                else if (r_cnt[i] == CW'(DEB_MS - 1)) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    // Lowest index wins among simultaneous presses
    always_comb begin
        w_pidx = 3'd0;
        w_cidx = 2'd0;
        for (int i = 4; i >= 0; i--) if (w_pp[i]) w_pidx = 3'(i);
        for (int i = 2; i >= 0; i--) if (w_cp[i]) w_cidx = 2'(i);
    end

    // Clear is applied before the coin so credit from a coincident coin survives
    assign w_val   = w_cidx == 2'd0 ? 5'(COIN0_VAL) : w_cidx == 2'd1 ? 5'(COIN1_VAL) : 5'(COIN2_VAL);
    assign w_base  = money_clr ? 5'd0 : {1'b0, r_money};
    assign w_sum   = w_base + w_val;
    assign w_multi = (w_cp & (w_cp - 3'd1)) != 3'd0;
    assign w_cok   = |w_cp && accept_coin && w_sum <= 5'd15;

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            r_prod         <= 4'h0;
            r_money        <= 4'h0;
            r_prod_pulse   <= 1'b0;
            r_coin_pulse   <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_cancel_pulse <= 1'b0;
        end else begin
            r_prod         <= (accept_sel && |w_pp) ? 4'(4'hA + {1'b0, w_pidx}) : money_clr ? 4'h0 : r_prod;
            r_money        <= w_cok ? w_sum[3:0] : w_base[3:0];
            r_prod_pulse   <= accept_sel && |w_pp;
            r_coin_pulse   <= w_cok;
            r_coin_reject  <= |w_cp && (!w_cok || w_multi);
            r_cancel_pulse <= w_press[8];
        end
    end

    assign CurrProd     = r_prod;
    assign money        = r_money;
    assign prod_pulse   = r_prod_pulse;
    assign coin_pulse   = r_coin_pulse;
    assign coin_reject  = r_coin_reject;
    assign cancel_pulse = r_cancel_pulse;
endmodule
